op_sched: RTL and testbench

OP_SCHED -- requirements
Module: op_sched

---
 rtl/op_sched_pkg.sv | 30 +++
 rtl/op_sched_mem_wait_timer.sv | 25 ++
 rtl/op_sched.sv | 111 +++++++++++
 tb/tb_op_sched.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/op_sched_pkg.sv
// Shared definitions for the operation scheduler: kind and state
// encodings, special ALU function codes and the memory wait limit.
package op_sched_pkg;

    typedef enum logic [1:0] {
        K_ALU_REG = 2'b00,
        K_ALU_IMM = 2'b01,
        K_LOAD    = 2'b10,
        K_STORE   = 2'b11
    } kind_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_MEM  = 2'b10
    } state_e;

    localparam logic [3:0] ALU_LDF = 4'b1110;
    localparam logic [3:0] ALU_STF = 4'b1111;
    localparam logic [7:0] TIMEOUT = 8'd255;

    typedef struct packed {
        kind_e       kind;
        logic [3:0]  alu_f;
        logic        carry_mask;
        logic [15:0] imm;
        logic        zero_index;
    } op_t;

endpackage

// File: rtl/op_sched_mem_wait_timer.sv
// Counts cycles spent waiting on the LSU; flags when the limit is hit.
module mem_wait_timer
    import op_sched_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && !expired)
            count <= count + 8'd1;
    end

    assign expired = (count == TIMEOUT);

endmodule

// File: rtl/op_sched.sv
// Issues decoded operations to the ALU directly or via the LSU,
// generating writeback enables and a memory wait timeout.
module op_sched
    import op_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_valid,
    output logic        dec_ready,
    input  logic [1:0]  dec_kind,
    input  logic [3:0]  dec_alu_f,
    input  logic        dec_carry_mask,
    input  logic [15:0] dec_imm,
    input  logic        dec_zero_index,
    output logic [3:0]  alu_f,
    output logic        carry_mask,
    output logic [15:0] sched_t16,
    output logic [15:0] sched_agu_t16,
    output logic        sched_bypass_b,
    output logic        sched_zero_index,
    output logic        rf_we,
    output logic        sf_we,
    output logic        lsu_req,
    output logic        lsu_we,
    input  logic        lsu_ack,
    input  logic [15:0] lsu_rdata,
    output logic        busy,
    output logic        mem_timeout
);

    state_e      state, state_nx;
    op_t         op;
    logic [15:0] operand;
    logic        accept;
    logic        expired;

    assign dec_ready = (state == S_IDLE) && !rst;
    assign accept    = dec_valid && dec_ready;
    assign busy      = (state != S_IDLE);

    mem_wait_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .enable  (state == S_MEM),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            op      <= '0;
            operand <= '0;
        end else begin
            state <= state_nx;
            if (accept)
                op <= '{kind_e'(dec_kind), dec_alu_f, dec_carry_mask,
                        dec_imm, dec_zero_index};
            if (state == S_MEM && lsu_ack && op.kind == K_LOAD)
                operand <= lsu_rdata;
        end
    end

    always_comb begin
        state_nx         = state;
        alu_f            = '0;
        carry_mask       = 1'b0;
        sched_t16        = '0;
        sched_agu_t16    = '0;
        sched_bypass_b   = 1'b0;
        sched_zero_index = 1'b0;
        rf_we            = 1'b0;
        sf_we            = 1'b0;
        lsu_req          = 1'b0;
        lsu_we           = 1'b0;
        mem_timeout      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept)
                    state_nx = dec_kind[1] ? S_MEM : S_EXEC;
            end
            S_MEM: begin
                lsu_req          = 1'b1;
                lsu_we           = (op.kind == K_STORE);
                sched_agu_t16    = op.imm;
                sched_zero_index = op.zero_index;
                // A late ack still wins over the timeout in the same cycle
                if (lsu_ack) begin
                    state_nx = (op.kind == K_STORE) ? S_IDLE : S_EXEC;
                end else if (expired) begin
                    mem_timeout = 1'b1;
                    state_nx    = S_IDLE;
                end
            end
            S_EXEC: begin
                alu_f          = op.alu_f;
                carry_mask     = op.carry_mask;
                sched_bypass_b = (op.kind != K_ALU_REG);
                if (op.kind == K_LOAD)
                    sched_t16 = operand;
                else if (op.kind == K_ALU_IMM)
                    sched_t16 = op.imm;
                rf_we    = (op.alu_f != ALU_STF);
                sf_we    = (op.alu_f != ALU_LDF);
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_op_sched.sv
// Randomized transaction-level bench for op_sched with directed corners
// (writeback exceptions, timeout boundary, reset mid-MEM).
module tb_op_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid;
    logic        dec_ready;
    logic [1:0]  dec_kind;
    logic [3:0]  dec_alu_f;
    logic        dec_carry_mask;
    logic [15:0] dec_imm;
    logic        dec_zero_index;
    logic [3:0]  alu_f;
    logic        carry_mask;
    logic [15:0] sched_t16;
    logic [15:0] sched_agu_t16;
    logic        sched_bypass_b;
    logic        sched_zero_index;
    logic        rf_we;
    logic        sf_we;
    logic        lsu_req;
    logic        lsu_we;
    logic        lsu_ack;
    logic [15:0] lsu_rdata;
    logic        busy;
    logic        mem_timeout;

    int checks = 0;
    int errors = 0;

    op_sched dut (
        .clk              (clk),
        .rst              (rst),
        .dec_valid        (dec_valid),
        .dec_ready        (dec_ready),
        .dec_kind         (dec_kind),
        .dec_alu_f        (dec_alu_f),
        .dec_carry_mask   (dec_carry_mask),
        .dec_imm          (dec_imm),
        .dec_zero_index   (dec_zero_index),
        .alu_f            (alu_f),
        .carry_mask       (carry_mask),
        .sched_t16        (sched_t16),
        .sched_agu_t16    (sched_agu_t16),
        .sched_bypass_b   (sched_bypass_b),
        .sched_zero_index (sched_zero_index),
        .rf_we            (rf_we),
        .sf_we            (sf_we),
        .lsu_req          (lsu_req),
        .lsu_we           (lsu_we),
        .lsu_ack          (lsu_ack),
        .lsu_rdata        (lsu_rdata),
        .busy             (busy),
        .mem_timeout      (mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ready"}, dec_ready, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_we"}, {rf_we, sf_we, lsu_req, lsu_we}, 4'b0);
        check({tag, "_to"}, mem_timeout, 1'b0);
        check({tag, "_data"}, {alu_f, sched_t16, sched_agu_t16},
              36'h0);
        check({tag, "_misc"}, {carry_mask, sched_bypass_b,
              sched_zero_index}, 3'b0);
    endtask

    // Called at posedge+1 with the scheduler idle; returns at posedge+1.
    // ack_at < 0 means the LSU never answers.
    task automatic run_op(input logic [1:0] k, input logic [3:0] f,
                          input logic cm, input logic [15:0] imm,
                          input logic zi, input int ack_at,
                          input logic [15:0] rd);
        bit wb;
        bit ack;
        logic [15:0] t16_exp;
        dec_valid      = 1'b1;
        dec_kind       = k;
        dec_alu_f      = f;
        dec_carry_mask = cm;
        dec_imm        = imm;
        dec_zero_index = zi;
        lsu_ack        = 1'($urandom);
        @(negedge clk);
        check_quiet("accept");
        @(posedge clk);
        #1;
        dec_valid      = 1'b0;
        dec_kind       = 2'($urandom);
        dec_alu_f      = 4'($urandom);
        dec_carry_mask = 1'($urandom);
        dec_imm        = 16'($urandom);
        dec_zero_index = 1'($urandom);
        wb = 1'b1;
        if (k[1]) begin
            for (int i = 0; i < 256; i++) begin
                ack       = (i == ack_at);
                lsu_ack   = ack;
                lsu_rdata = ack ? rd : 16'($urandom);
                @(negedge clk);
                check("mem_req", {lsu_req, busy, dec_ready}, 3'b110);
                check("mem_lsu_we", lsu_we, k == 2'b11);
                check("mem_agu", sched_agu_t16, imm);
                check("mem_zi", sched_zero_index, zi);
                check("mem_no_wb", {rf_we, sf_we}, 2'b0);
                check("mem_timeout", mem_timeout, !ack && i == 255);
                @(posedge clk);
                #1;
                lsu_ack = 1'b0;
                if (ack)
                    break;
                if (i == 255) begin
                    wb = 1'b0;
                    break;
                end
            end
            if (k == 2'b11)
                wb = 1'b0;
        end
        if (wb) begin
            case (k)
                2'b00:   t16_exp = 16'h0;
                2'b01:   t16_exp = imm;
                default: t16_exp = rd;
            endcase
            @(negedge clk);
            check("ex_ctrl", {alu_f, carry_mask}, {f, cm});
            check("ex_bypass", sched_bypass_b, k != 2'b00);
            check("ex_t16", sched_t16, t16_exp);
            check("ex_rf_we", rf_we, f != 4'b1111);
            check("ex_sf_we", sf_we, f != 4'b1110);
            check("ex_state", {busy, dec_ready, lsu_req, mem_timeout},
                  4'b1000);
            @(posedge clk);
            #1;
        end
        lsu_ack = 1'($urandom);
        @(negedge clk);
        check_quiet("done");
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        dec_valid      = 1'b0;
        dec_kind       = '0;
        dec_alu_f      = '0;
        dec_carry_mask = 1'b0;
        dec_imm        = '0;
        dec_zero_index = 1'b0;
        lsu_ack        = 1'b0;
        lsu_rdata      = '0;
        #2;
        check("rst_ready", dec_ready, 1'b0);
        check("rst_outs", {busy, rf_we, sf_we, lsu_req, mem_timeout},
              5'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_quiet("post_rst");
        @(posedge clk);
        #1;

        run_op(2'b01, 4'b0000, 1'b0, 16'h0005, 1'b0, 0, 16'h0);
        run_op(2'b10, 4'b0011, 1'b1, 16'h1000, 1'b1, 2, 16'hBEEF);
        run_op(2'b11, 4'b0101, 1'b0, 16'h2222, 1'b0, 0, 16'h0);
        run_op(2'b00, 4'b1111, 1'b1, 16'h3333, 1'b0, 0, 16'h0);
        run_op(2'b00, 4'b1110, 1'b0, 16'h4444, 1'b0, 0, 16'h0);
        run_op(2'b10, 4'b0001, 1'b0, 16'h0ABC, 1'b0, -1, 16'h0);
        run_op(2'b10, 4'b0010, 1'b1, 16'h0DEF, 1'b1, 255, 16'h1234);
        run_op(2'b11, 4'b0110, 1'b0, 16'h5555, 1'b1, -1, 16'h0);

        for (int n = 0; n < 60; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                lsu_ack = 1'($urandom);
                @(posedge clk);
                #1;
            end
            run_op(2'($urandom), 4'($urandom), 1'($urandom),
                   16'($urandom), 1'($urandom),
                   int'($urandom_range(0, 6)), 16'($urandom));
        end

        // Reset in the middle of a LOAD's MEM wait
        dec_valid = 1'b1;
        dec_kind  = 2'b10;
        dec_alu_f = 4'b0000;
        dec_imm   = 16'h7777;
        lsu_ack   = 1'b0;
        @(posedge clk);
        #1;
        dec_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("pre_rst_mem", lsu_req, 1'b1);
        rst = 1'b1;
        #1;
        check("async_rst_outs",
              {busy, dec_ready, lsu_req, lsu_we, rf_we, sf_we,
               mem_timeout}, 7'b0);
        check("async_rst_agu", sched_agu_t16, 16'h0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            lsu_ack   = 1'b1;
            lsu_rdata = 16'hFFFF;
            @(negedge clk);
            check_quiet("after_rst");
        end
        lsu_ack = 1'b0;
        @(posedge clk);
        #1;
        run_op(2'b01, 4'b0100, 1'b1, 16'h00FF, 1'b0, 0, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
